// File: rtl/neuron_store_bank_if.sv
// Request/response bundle for neuron_store_bank: write, clear and tap-read ports.
// The master drives the write/clear/read controls; the slave returns the registered read data.
interface neuron_store_bank_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 2,
    parameter int TW    = 3
);
    logic             wr_en;
    logic [CW-1:0]    wr_ch;
    logic [WIDTH-1:0] in;
    logic             clr;
    logic [CW-1:0]    clr_ch;
    logic [CW-1:0]    rd_ch;
    logic [TW-1:0]    rd_tap;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [TW:0]      rd_count;

    modport master (
        output wr_en, wr_ch, in, clr, clr_ch, rd_ch, rd_tap,
        input  out, out_valid, rd_count
    );

    modport slave (
        input  wr_en, wr_ch, in, clr, clr_ch, rd_ch, rd_tap,
        output out, out_valid, rd_count
    );
endinterface

// File: rtl/neuron_store_bank.sv
// Multi-channel history store: each channel is a DEPTH-deep ring buffer with a fill count.
// Samples are read by age (tap 0 = newest), with one active edge of latency.
module neuron_store_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    parameter int NEG_EDGE = 1
) (
    input logic               clk,
    input logic               rst,
    neuron_store_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW = $clog2(DEPTH);

    // One register clock; the inversion picks the falling edge without duplicating the update logic.
    logic aclk;
    assign aclk = clk ^ (NEG_EDGE != 0);

    logic [WIDTH-1:0] mem  [CHANNELS][DEPTH];
    logic [TW-1:0]    wptr [CHANNELS];
    logic [TW:0]      cnt  [CHANNELS];

    logic [CHANNELS-1:0] clr_hit, wr_hit;
    logic [TW-1:0]       wbase  [CHANNELS];
    logic [TW-1:0]       wptr_n [CHANNELS];
    logic [TW:0]         cbase  [CHANNELS];
    logic [TW:0]         cnt_n  [CHANNELS];

    // A clear rebases the channel first, so a same-edge write lands at entry 0 with count 1.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            clr_hit[c] = bus.clr   && (bus.clr_ch == CW'(c));
            wr_hit[c]  = bus.wr_en && (bus.wr_ch  == CW'(c));
            wbase[c]   = clr_hit[c] ? '0 : wptr[c];
            cbase[c]   = clr_hit[c] ? '0 : cnt[c];
            wptr_n[c]  = wr_hit[c] ? wbase[c] + TW'(1) : wbase[c];
            cnt_n[c]   = (wr_hit[c] && cbase[c] != (TW+1)'(DEPTH)) ? cbase[c] + (TW+1)'(1)
                                                                    : cbase[c];
        end
    end

    logic          rd_in, rd_hit;
    logic [TW:0]   rd_cnt;
    logic [TW-1:0] raddr;

    always_comb begin
        rd_in  = {1'b0, bus.rd_ch} < (CW+1)'(CHANNELS);
        rd_cnt = rd_in ? cnt[bus.rd_ch] : '0;
        rd_hit = rd_in && ({1'b0, bus.rd_tap} < rd_cnt);
        raddr  = rd_in ? wptr[bus.rd_ch] - TW'(1) - bus.rd_tap : '0;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
            end
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.rd_count  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr[c] <= wptr_n[c];
                cnt[c]  <= cnt_n[c];
            end
            bus.out       <= rd_hit ? mem[bus.rd_ch][raddr] : '0;
            bus.out_valid <= rd_hit;
            bus.rd_count  <= rd_cnt;
        end
    end

    // Sample storage carries no reset; the counts alone define what is valid.
    always_ff @(posedge aclk) begin
        for (int c = 0; c < CHANNELS; c++)
            if (!rst && wr_hit[c]) mem[c][wbase[c]] <= bus.in;
    end
endmodule

// File: doc/neuron_store_bank.md
NEURON_STORE_BANK -- requirements
Module: neuron_store_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning sample width in bits (signed two's complement).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent neuron channels (>=1).
REQ-003 SHALL have parameter DEPTH, default 8, meaning per-channel history depth (power of two, >=2).
REQ-004 SHALL have parameter NEG_EDGE, default 1, meaning 1 = all state updates on falling clk edge, 0 = rising edge.
REQ-005 SHALL define CW = max(1, clog2(CHANNELS)) and TW = clog2(DEPTH).
REQ-006 SHALL have port clk  input  1  single clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high, sampled on the active edge selected by NEG_EDGE.
REQ-008 SHALL have port wr_en  input  1  push sample in into channel wr_ch.
REQ-009 SHALL have port wr_ch  input  CW  target channel for the write.
REQ-010 SHALL have port in  input  WIDTH  sample to store.
REQ-011 SHALL have port clr  input  1  flush history of channel clr_ch.
REQ-012 SHALL have port clr_ch  input  CW  channel to flush.
REQ-013 SHALL have port rd_ch  input  CW  channel to read.
REQ-014 SHALL have port rd_tap  input  TW  age of sample to read (0 = newest).
REQ-015 SHALL have port out  output  WIDTH  registered read data.
REQ-016 SHALL have port out_valid  output  1  out holds a stored sample.
REQ-017 SHALL have port rd_count  output  TW+1  registered fill level of rd_ch.

Function
REQ-018 SHALL keep per channel a DEPTH-entry ring buffer, a write pointer (TW bits) and a fill count (0..DEPTH).
REQ-019 Write: on the active edge with wr_en=1, SHALL store in at the channel's write pointer, increment the pointer modulo DEPTH, and increment the count saturating at DEPTH.
REQ-020 Write when full (count=DEPTH) SHALL overwrite the oldest sample; count stays DEPTH.
REQ-021 Clear: on the active edge with clr=1, SHALL set clr_ch's count and write pointer to 0; stored data need not be zeroed.
REQ-022 clr and wr_en to the same channel in the same edge SHALL yield count=1 with in stored at entry 0.
REQ-023 clr and wr_en to different channels in the same edge SHALL both take effect independently.
REQ-024 Read: on every active edge, out SHALL load the sample written rd_tap writes before the newest in rd_ch, i.e. entry (wptr-1-rd_tap) mod DEPTH, from pre-edge state.
REQ-025 Read latency SHALL be one active edge; a write to rd_ch in the same edge SHALL NOT be visible until the next edge.
REQ-026 out_valid SHALL load 1 when rd_tap < pre-edge count of rd_ch, else 0; when 0, out SHALL load 0.
REQ-027 rd_count SHALL load the pre-edge count of rd_ch on every active edge.
REQ-028 wr_ch, clr_ch or rd_ch >= CHANNELS SHALL be ignored for writes/clears and SHALL produce out=0, out_valid=0, rd_count=0 for reads.
REQ-029 No state SHALL change on the inactive clk edge.
REQ-030 in SHALL be stored bit-exact; no arithmetic on data.

Reset
REQ-031 With rst=1 at an active edge: all counts and write pointers SHALL be 0, out=0, out_valid=0, rd_count=0.
REQ-032 rst SHALL take priority over wr_en and clr in the same edge; buffer contents need not be cleared.
REQ-033 Reset mid-operation SHALL discard all history; first read after reset deasserts SHALL return out_valid=0.

Verification
REQ-034 Defaults, reset, write ch1 values 5,1,8,9 on successive falling edges, read ch1 tap0..3 -> out 9,8,1,5, out_valid=1, rd_count=4; ch0 tap0 -> out=0, out_valid=0.
REQ-035 Write ch2 values 1..10 (DEPTH=8), read tap0 -> 10, tap7 -> 3, rd_count=8.
REQ-036 Same edge write ch0=7 and read ch0 tap0 on empty ch0 -> out_valid=0 that edge, next edge out=7, out_valid=1.
REQ-037 ch3 holds 4 samples; same edge clr ch3 and wr ch3=42 -> next read tap0 = 42, rd_count=1, tap1 -> out_valid=0.
REQ-038 Fill ch0, assert rst one edge while wr_en=1 -> rd_count=0, out_valid=0; rising edges alone never change outputs (NEG_EDGE=1).
REQ-039 NEG_EDGE=0 instance repeating REQ-034 -> identical values, updates on rising edges only.
